// File: rtl/cipher_dp_seq.sv
// Iterative byte-serial block cipher: load, expand keys, run rounds, present.
// State updates on the falling edge of clka; restart is async active-high.
module cipher_dp_seq #(
  parameter int         W       = 16,
  parameter int         ROUNDS  = 3,
  parameter logic [7:0] RC_SEED = 8'h9D
) (
  input  logic         clka,
  input  logic         restart,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   d_in,
  input  logic [7:0]   key_in,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic [W-1:0] key_out,
  output logic         busy
);

  localparam int NB = W / 8;

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_KEYEXP = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  if (W % 8 != 0 || W < 16 || W > 64) begin : g_bad_w
    $error("cipher_dp_seq: W must be a multiple of 8 in 16..64");
  end
  if (ROUNDS < 1 || ROUNDS > 8) begin : g_bad_r
    $error("cipher_dp_seq: ROUNDS must be in 1..8");
  end

  logic [1:0]   state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [2:0]   rnd_q, rnd_d;
  logic         mode_q, mode_d;
  logic         ov_q, ov_d;
  logic [W-1:0] data_q, data_d;
  logic [W-1:0] key_q, key_d;
  logic [W-1:0] dout_q, dout_d;
  logic [W-1:0] kout_q, kout_d;
  logic [W-1:0] ks_q [ROUNDS];
  logic [W-1:0] ks_d [ROUNDS];

  logic [2:0]   kidx;
  logic [W-1:0] rk, knext, dx, rnd_out;
  logic [W-1:0] data_sh, key_sh;
  logic         last_beat, last_rnd;

  function automatic logic [7:0] rc(input logic [2:0] i);
    logic [15:0] t;
    t = {RC_SEED, RC_SEED} << i;
    return t[15:8] ^ {5'd0, i};
  endfunction

  // Decrypt walks the key store backwards.
  always_comb begin
    kidx = rnd_q;
    if (state_q == S_RUN && mode_q)
      kidx = 3'(ROUNDS - 1) - rnd_q;
    rk = '0;
    for (int i = 0; i < ROUNDS; i++)
      if (kidx == 3'(i)) rk = ks_q[i];
  end

  assign knext   = {rk[W-4:0], rk[W-1:W-3]} ^ {NB{rc(rnd_q)}};
  assign dx      = data_q ^ rk;
  assign rnd_out = mode_q ? ({data_q[0], data_q[W-1:1]} ^ rk)
                          : {dx[W-2:0], dx[W-1]};
  assign data_sh = {data_q[W-9:0], d_in};
  assign key_sh  = {key_q[W-9:0], key_in};

  assign last_beat = cnt_q == 3'(NB - 1);
  assign last_rnd  = rnd_q == 3'(ROUNDS - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
    mode_d  = mode_q;
    ov_d    = ov_q;
    data_d  = data_q;
    key_d   = key_q;
    dout_d  = dout_q;
    kout_d  = kout_q;
    ks_d    = ks_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          data_d = data_sh;
          key_d  = key_sh;
          cnt_d  = cnt_q + 3'd1;
          if (last_beat) begin
            cnt_d    = '0;
            mode_d   = mode;
            ks_d[0]  = key_sh;
            state_d  = (ROUNDS == 1) ? S_RUN : S_KEYEXP;
          end
        end
      end
      S_KEYEXP: begin
        for (int i = 1; i < ROUNDS; i++)
          if (rnd_q == 3'(i - 1)) ks_d[i] = knext;
        rnd_d = rnd_q + 3'd1;
        if (rnd_q == 3'(ROUNDS - 2)) begin
          rnd_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        data_d = rnd_out;
        rnd_d  = rnd_q + 3'd1;
        if (last_rnd) begin
          rnd_d   = '0;
          dout_d  = rnd_out;
          kout_d  = key_q;
          ov_d    = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(negedge clka or posedge restart) begin
    if (restart) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      rnd_q   <= '0;
      mode_q  <= 1'b0;
      ov_q    <= 1'b0;
      data_q  <= '0;
      key_q   <= '0;
      dout_q  <= '0;
      kout_q  <= '0;
      for (int i = 0; i < ROUNDS; i++) ks_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
      mode_q  <= mode_d;
      ov_q    <= ov_d;
      data_q  <= data_d;
      key_q   <= key_d;
      dout_q  <= dout_d;
      kout_q  <= kout_d;
      ks_q    <= ks_d;
    end
  end

  // in_ready is forced low while restart is held.
  assign in_ready  = (state_q == S_LOAD) & ~restart;
  assign busy      = state_q != S_LOAD;
  assign out_valid = ov_q;
  assign data_out  = dout_q;
  assign key_out   = kout_q;

endmodule

// File: tb/tb_cipher_dp_seq.sv
// Scoreboard bench for cipher_dp_seq across three W/ROUNDS configurations.
// Unit 0: W16 R1, unit 1: W16 R2, unit 2: W32 R8.
module tb_cipher_dp_seq;

  localparam int WU [3] = '{16, 16, 32};
  localparam int RU [3] = '{1, 2, 8};

  logic       clka = 1'b0;
  logic       restart = 1'b0;
  logic [2:0] iv = '0, md = '0, ordy = '0;
  logic [2:0] ir, ov, bz;
  logic [7:0] din [3];
  logic [7:0] kin [3];
  logic [15:0] d0, k0, d1, k1;
  logic [31:0] d2, k2;
  logic [63:0] dout [3];
  logic [63:0] kout [3];

  assign dout[0] = {48'd0, d0};
  assign dout[1] = {48'd0, d1};
  assign dout[2] = {32'd0, d2};
  assign kout[0] = {48'd0, k0};
  assign kout[1] = {48'd0, k1};
  assign kout[2] = {32'd0, k2};

  always #5 clka = ~clka;

  cipher_dp_seq #(.W(16), .ROUNDS(1)) u0 (
    .clka(clka), .restart(restart),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .d_in(din[0]), .key_in(kin[0]), .mode(md[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .data_out(d0), .key_out(k0), .busy(bz[0]));

  cipher_dp_seq #(.W(16), .ROUNDS(2)) u1 (
    .clka(clka), .restart(restart),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .d_in(din[1]), .key_in(kin[1]), .mode(md[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .data_out(d1), .key_out(k1), .busy(bz[1]));

  cipher_dp_seq #(.W(32), .ROUNDS(8)) u2 (
    .clka(clka), .restart(restart),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .d_in(din[2]), .key_in(kin[2]), .mode(md[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .data_out(d2), .key_out(k2), .busy(bz[2]));

  typedef struct {
    int          u;
    logic [63:0] d;
    logic [63:0] k;
  } sb_t;

  sb_t sb [$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mask_m(int w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] rotl_m(logic [63:0] x,
                                         int n, int w);
    return ((x << n) | (x >> (w - n))) & mask_m(w);
  endfunction

  function automatic logic [63:0] rotr_m(logic [63:0] x, int w);
    return ((x >> 1) | (x << (w - 1))) & mask_m(w);
  endfunction

  function automatic logic [7:0] rc_m(int i);
    logic [7:0] s;
    logic [7:0] t;
    s = 8'h9D;
    t = (s << i) | (s >> (8 - i));
    return t ^ 8'(i);
  endfunction

  function automatic logic [63:0] model(int w, int r,
      logic [63:0] key, logic [63:0] d, logic dec);
    logic [63:0] k [8];
    logic [63:0] rp;
    k[0] = key;
    for (int i = 1; i < r; i++) begin
      rp = '0;
      for (int b = 0; b < w / 8; b++)
        rp |= 64'(rc_m(i - 1)) << (8 * b);
      k[i] = rotl_m(k[i-1], 3, w) ^ rp;
    end
    for (int i = 0; i < r; i++)
      d = dec ? (rotr_m(d, w) ^ k[r-1-i])
              : rotl_m(d ^ k[i], 1, w);
    return d;
  endfunction

  // Mode is inverted on all but the last beat.
  task automatic load(int u, logic [63:0] d, logic [63:0] k,
                      logic m, bit gap);
    for (int b = WU[u] / 8 - 1; b >= 0; b--) begin
      @(posedge clka);
      iv[u]  = 1'b1;
      din[u] = d[8*b +: 8];
      kin[u] = k[8*b +: 8];
      md[u]  = (b == 0) ? m : ~m;
      if (gap && b > 0) begin
        @(posedge clka);
        iv[u]  = 1'b0;
        din[u] = 8'hA5;
        kin[u] = 8'h5A;
      end
    end
    @(posedge clka);
    iv[u] = 1'b0;
  endtask

  task automatic collect(int u, int hold);
    int  lat;
    sb_t e;
    lat = 0;
    while (!ov[u] && lat < 40) begin
      @(posedge clka);
      lat++;
    end
    check("latency", 64'(lat), 64'(2 * RU[u] - 1));
    e = sb.pop_front();
    check("data_out", dout[u], e.d);
    check("key_out", kout[u], e.k);
    for (int i = 0; i < hold; i++) begin
      iv[u]  = i[0];
      din[u] = 8'hFF;
      kin[u] = 8'hFF;
      @(posedge clka);
      check("hold_ov", 64'(ov[u]), 64'd1);
      check("hold_ir", 64'(ir[u]), 64'd0);
      check("hold_dout", dout[u], e.d);
    end
    iv[u]   = 1'b0;
    ordy[u] = 1'b1;
    @(posedge clka);
    check("hs_ov", 64'(ov[u]), 64'd0);
    check("hs_ir", 64'(ir[u]), 64'd1);
    ordy[u] = 1'b0;
  endtask

  task automatic run(int u, logic [63:0] d, logic [63:0] k,
                     logic m, bit gap, logic [63:0] exp,
                     int hold);
    sb_t e;
    e.u = u;
    e.d = exp;
    e.k = k;
    sb.push_back(e);
    load(u, d, k, m, gap);
    collect(u, hold);
  endtask

  initial begin
    logic [63:0] x, k, y;
    for (int u = 0; u < 3; u++) begin
      din[u] = '0;
      kin[u] = '0;
    end
    #1 restart = 1'b1;
    repeat (2) @(posedge clka);
    check("rst_ir_held", 64'(ir), 64'd0);
    restart = 1'b0;
    @(posedge clka);
    for (int u = 0; u < 3; u++) begin
      check("rst_ir", 64'(ir[u]), 64'd1);
      check("rst_ov", 64'(ov[u]), 64'd0);
      check("rst_busy", 64'(bz[u]), 64'd0);
      check("rst_dout", dout[u], 64'd0);
      check("rst_kout", kout[u], 64'd0);
    end

    run(0, 64'h0001, 64'h0000, 1'b0, 1'b0, 64'h0002, 0);
    run(0, 64'h0000, 64'h00FF, 1'b0, 1'b0, 64'h01FE, 0);
    run(0, 64'h01FE, 64'h00FF, 1'b1, 1'b0, 64'h0000, 0);
    run(1, 64'h0000, 64'h0000, 1'b0, 1'b0, 64'h3B3B, 0);
    run(1, 64'h3B3B, 64'h0000, 1'b1, 1'b0, 64'h0000, 0);

    y = model(16, 2, 64'hBEEF, 64'h1234, 1'b0);
    run(1, 64'h1234, 64'hBEEF, 1'b0, 1'b0, y, 5);
    run(1, 64'h1234, 64'hBEEF, 1'b0, 1'b1, y, 0);
    run(1, y, 64'hBEEF, 1'b1, 1'b1, 64'h1234, 0);

    ordy[0] = 1'b1;
    y = model(16, 1, 64'hC3A5, 64'h7E81, 1'b0);
    run(0, 64'h7E81, 64'hC3A5, 1'b0, 1'b0, y, 0);

    y = model(32, 8, 64'h01234567, 64'hDEADBEEF, 1'b0);
    run(2, 64'hDEADBEEF, 64'h01234567, 1'b0, 1'b1, y, 0);

    load(2, 64'h11223344, 64'h55667788, 1'b0, 1'b0);
    repeat (9) @(posedge clka);
    check("run_busy", 64'(bz[2]), 64'd1);
    #2 restart = 1'b1;
    #1;
    check("abort_dout", dout[2], 64'd0);
    check("abort_kout", kout[2], 64'd0);
    check("abort_ov", 64'(ov[2]), 64'd0);
    check("abort_busy", 64'(bz[2]), 64'd0);
    check("abort_ir", 64'(ir[2]), 64'd0);
    @(posedge clka);
    restart = 1'b0;
    @(posedge clka);
    check("abort_ir_rel", 64'(ir[2]), 64'd1);
    y = model(32, 8, 64'h55667788, 64'h11223344, 1'b0);
    run(2, 64'h11223344, 64'h55667788, 1'b0, 1'b0, y, 0);

    for (int i = 0; i < 1000; i++) begin
      x = 64'($urandom);
      k = 64'($urandom);
      y = model(32, 8, k, x, 1'b0);
      run(2, x, k, 1'b0, (i % 50) == 0, y, 0);
      run(2, y, k, 1'b1, 1'b0, x, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
